mdu_sequencer: RTL and testbench

Iterative multiply/divide unit and controller that sequences the multi-cycle ALU operations (MULT, MULTU, DIV, DIVU) for the MIPS execute stage. It owns the architectural HI/LO registers and performs one shift-add or restoring-subtract step per cycle. It exposes a start/busy/done handshake so the pipeline control can stall on MFHI/MFLO while an operation is in flight.

---
 rtl/mdu_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// mdu_sequencer
// Iterative multiply/divide unit for the execute stage. It owns the
// architectural HI/LO registers. Each cycle in CALC it performs one shift-add
// (multiply) or one restoring-subtract step (divide).
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, op, a, b   operation request (op: 0=MULT 1=MULTU 2=DIV 3=DIVU),
//                     sampled only in IDLE
//   cancel            flushes an in-flight operation (CALC/FIX) back to IDLE
//   hi_we, lo_we,     MTHI/MTLO writes, honoured only while not busy
//   wdata
//   busy              high in CALC and FIX
//   done              one-cycle pulse in DONE
//   div_zero          high with done when a divide had b==0
//   hi, lo            HI/LO registers
module mdu_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cancel,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [CW-1:0]       count_r;
  logic                is_div_r, sign_q_r, sign_r_r, dz_r;
  logic [XLEN-1:0]     mcand_r;   // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc_r;     // product, or dividend shifting into quotient
  logic [XLEN:0]       rem_r;     // partial remainder
  logic [XLEN-1:0]     hi_r, lo_r;
  logic                busy_r, done_r, div_zero_r;

  logic                accept_s, signed_op_s;
  logic [XLEN-1:0]     a_mag_s, b_mag_s;
  logic [XLEN:0]       mul_sum_s;
  logic [2*XLEN-1:0]   mul_step_s;
  logic [XLEN:0]       div_shift_s, div_diff_s;
  logic                div_ge_s;
  logic [2*XLEN-1:0]   fix_prod_s;
  logic [XLEN-1:0]     fix_quot_s, fix_rem_s;

  // Operand conditioning at start: signed ops work on magnitudes
  always_comb begin
    accept_s    = (state_r == S_IDLE) && start && !cancel;
    signed_op_s = !op[0];
    if (signed_op_s && a[XLEN-1]) a_mag_s = -a;
    else                          a_mag_s = a;
    if (signed_op_s && b[XLEN-1]) b_mag_s = -b;
    else                          b_mag_s = b;
  end

  // One iteration step for multiply and divide, plus the FIX-stage sign fixups
  always_comb begin
    mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, mcand_r};
    if (acc_r[0]) mul_step_s = {mul_sum_s, acc_r[XLEN-1:1]};
    else          mul_step_s = {1'b0, acc_r[2*XLEN-1:1]};

    div_shift_s = {rem_r[XLEN-1:0], acc_r[XLEN-1]};
    // A set top bit would mean the remainder already exceeds any divisor
    div_ge_s    = rem_r[XLEN] || (div_shift_s >= {1'b0, mcand_r});
    div_diff_s  = div_shift_s - {1'b0, mcand_r};

    if (sign_q_r) fix_prod_s = -acc_r;
    else          fix_prod_s = acc_r;
    // Divide by zero: quotient all ones; the remainder path already yields
    // the raw dividend (|a| re-negated by sign_r gives a back).
    if (dz_r)          fix_quot_s = {XLEN{1'b1}};
    else if (sign_q_r) fix_quot_s = -acc_r[XLEN-1:0];
    else               fix_quot_s = acc_r[XLEN-1:0];
    if (sign_r_r) fix_rem_s = -rem_r[XLEN-1:0];
    else          fix_rem_s = rem_r[XLEN-1:0];
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_nxt_s = S_CALC;
        else          state_nxt_s = S_IDLE;
      end
      S_CALC: begin
        if (cancel)                   state_nxt_s = S_IDLE;
        else if (count_r == CNT_LAST) state_nxt_s = S_FIX;
        else                          state_nxt_s = S_CALC;
      end
      S_FIX: begin
        if (cancel) state_nxt_s = S_IDLE;
        else        state_nxt_s = S_DONE;
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      busy_r     <= (state_nxt_s == S_CALC) || (state_nxt_s == S_FIX);
      done_r     <= (state_nxt_s == S_DONE);
      div_zero_r <= (state_nxt_s == S_DONE) && dz_r;
    end
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r  <= '0;
      is_div_r <= 1'b0;
      sign_q_r <= 1'b0;
      sign_r_r <= 1'b0;
      dz_r     <= 1'b0;
      mcand_r  <= '0;
      acc_r    <= '0;
      rem_r    <= '0;
    end else if (accept_s) begin
      count_r  <= '0;
      is_div_r <= op[1];
      sign_q_r <= signed_op_s && (a[XLEN-1] ^ b[XLEN-1]);
      sign_r_r <= signed_op_s && a[XLEN-1];
      dz_r     <= op[1] && (b == {XLEN{1'b0}});
      mcand_r  <= op[1] ? b_mag_s : a_mag_s;
      // Multiply: multiplier in the low half. Divide: dividend in the low half.
      acc_r    <= {{XLEN{1'b0}}, (op[1] ? a_mag_s : b_mag_s)};
      rem_r    <= '0;
    end else if (state_r == S_CALC) begin
      count_r <= count_r + CNT_ONE;
      if (is_div_r) begin
        acc_r <= {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-2:0], div_ge_s};
        rem_r <= div_ge_s ? div_diff_s : div_shift_s;
      end else begin
        acc_r <= mul_step_s;
        rem_r <= rem_r;
      end
    end else begin
      count_r <= count_r;
      acc_r   <= acc_r;
      rem_r   <= rem_r;
    end
  end

  // HI/LO: result commit in FIX, MTHI/MTLO only while not busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if ((state_r == S_FIX) && !cancel) begin
      if (is_div_r) begin
        hi_r <= fix_rem_s;
        lo_r <= fix_quot_s;
      end else begin
        hi_r <= fix_prod_s[2*XLEN-1:XLEN];
        lo_r <= fix_prod_s[XLEN-1:0];
      end
    end else if ((state_r == S_IDLE) || (state_r == S_DONE)) begin
      if (hi_we) hi_r <= wdata;
      if (lo_we) lo_r <= wdata;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, cancel, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: architectural results straight from MIPS arithmetic rules
  function automatic logic [63:0] ref_result(input logic [1:0] f_op,
                                             input logic [31:0] fa,
                                             input logic [31:0] fb);
    longint sp;
    int     sa, sb, q, r;
    sa = fa;
    sb = fb;
    case (f_op)
      2'd0: begin
        sp = longint'(sa) * longint'(sb);
        return sp;
      end
      2'd1: return {32'h0, fa} * {32'h0, fb};
      2'd2: begin
        if (fb == 32'h0) return {fa, 32'hFFFFFFFF};
        if (fa == 32'h80000000 && fb == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (fb == 32'h0) return {fa, 32'hFFFFFFFF};
        return {fa % fb, fa / fb};
      end
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [1:0] t_op,
                        input logic [31:0] ta, input logic [31:0] tb_v);
    logic [63:0] expv;
    int cyc;
    expv = ref_result(t_op, ta, tb_v);
    @(negedge clk);
    op = t_op; a = ta; b = tb_v; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    chk({tag, ".busy"}, {31'h0, busy}, 32'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, ".latency"}, cyc, 32'd33);
    chk({tag, ".hi"}, hi, expv[63:32]);
    chk({tag, ".lo"}, lo, expv[31:0]);
    chk({tag, ".dz"}, {31'h0, div_zero}, {31'h0, (t_op[1] && tb_v == 32'h0)});
    chk({tag, ".busy_done"}, {31'h0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, {31'h0, done}, 32'd0);
    chk({tag, ".dz_pulse"}, {31'h0, div_zero}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'd0; a = 32'h0; b = 32'h0; wdata = 32'h0;
    #12;
    chk("reset.busy", {31'h0, busy}, 32'd0);
    chk("reset.done", {31'h0, done}, 32'd0);
    chk("reset.dz", {31'h0, div_zero}, 32'd0);
    chk("reset.hi", hi, 32'h0);
    chk("reset.lo", lo, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op("mult_neg", 2'd0, 32'hFFFFFFFD, 32'd7);
    chk("mult_neg.hi_abs", hi, 32'hFFFFFFFF);
    chk("mult_neg.lo_abs", lo, 32'hFFFFFFEB);
    run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_max.hi_abs", hi, 32'hFFFFFFFE);
    run_op("div_neg", 2'd2, 32'hFFFFFFF9, 32'd2);
    chk("div_neg.lo_abs", lo, 32'hFFFFFFFD);
    run_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf.lo_abs", lo, 32'h80000000);
    run_op("divu_zero", 2'd3, 32'd100, 32'd0);
    chk("divu_zero.hi_abs", hi, 32'h64);
    run_op("div_zero_neg", 2'd2, 32'hFFFFFF00, 32'd0);
    run_op("div_remsign", 2'd2, 32'd7, 32'hFFFFFFFE);

    // Randomized cases, with small divisors and zero mixed in
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) rb = 32'($urandom_range(0, 9));
      if (i % 8 == 3) rb = 32'h0;
      run_op($sformatf("rand%0d", i), 2'(i % 4), ra, rb);
    end

    // MTHI/MTLO preload, then cancel mid-CALC
    @(negedge clk);
    wdata = 32'h1234; hi_we = 1'b1;
    @(negedge clk);
    hi_we = 1'b0; wdata = 32'h5678; lo_we = 1'b1;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mt.hi", hi, 32'h1234);
    chk("mt.lo", lo, 32'h5678);
    op = 2'd1; a = 32'd5; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel.busy", {31'h0, busy}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) chk("cancel.nodone", {31'h0, done}, 32'd0);
    end
    chk("cancel.hi", hi, 32'h1234);
    chk("cancel.lo", lo, 32'h5678);

    // Cancel together with start in IDLE: start dropped
    op = 2'd1; a = 32'd3; b = 32'd3; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start.busy", {31'h0, busy}, 32'd0);

    // hi_we and start pulses while busy are ignored
    op = 2'd1; a = 32'd5; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    hi_we = 1'b0;
    chk("busy_we.hi", hi, 32'h1234);
    op = 2'd0; a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60 && done !== 1'b1; i++) @(negedge clk);
    chk("busy_start.done", {31'h0, done}, 32'd1);
    chk("busy_start.hi", hi, 32'h0);
    chk("busy_start.lo", lo, 32'd25);
    // Write landing in DONE takes effect
    lo_we = 1'b1; wdata = 32'hABC;
    @(negedge clk);
    lo_we = 1'b0;
    chk("done_we.lo", lo, 32'hABC);
    chk("done_we.busy", {31'h0, busy}, 32'd0);

    // Asynchronous reset in the middle of a divide
    op = 2'd2; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.busy", {31'h0, busy}, 32'd0);
    chk("midrst.done", {31'h0, done}, 32'd0);
    chk("midrst.hi", hi, 32'h0);
    chk("midrst.lo", lo, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 2'd3, 32'd1000, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
